// File: rtl/detect_pkg.sv
// detect_pkg: shared types for the detect_scheduler slice.
//   ctrl_state_t - scheduler controller states (IDLE, SHIFT, DONE)
//   det_state_t  - "10" detector states (S0, S1 = previous bit was 1)
package detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  typedef enum logic {
    S0 = 1'b0,
    S1 = 1'b1
  } det_state_t;

endpackage

// File: rtl/seq10_detector.sv
// seq10_detector: bit-serial Mealy detector for the pattern "10".
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear to S0 (wins over en)
//   en         - advance on x this cycle; when low, state holds and hit is 0
//   x          - serial input bit
//   hit        - high in the cycle a 0 follows a 1
module seq10_detector
  import detect_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic hit
);

  det_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (clr) begin
      state_d = S0;
    end else if (en) begin
      hit     = (state_q == S1) && !x;
      state_d = x ? S1 : S0;
    end
  end

endmodule

// File: rtl/detect_scheduler.sv
// detect_scheduler: round-robin sharing of one seq10_detector between NREQ
// requesters. A granted word is shifted MSB-first through the detector and
// the number of "10" detections is returned with a done strobe.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   req        - per-requester request level
//   data       - requester i word at data[i*WIDTH +: WIDTH]
//   grant      - one-hot acceptance pulse
//   busy       - job in progress (SHIFT or DONE)
//   done       - one-cycle completion strobe
//   done_id    - requester index of the completed job (held until next done)
//   match_cnt  - detection count of the completed job (held until next done)
//
// Handshake: req is a level that acts as "valid"; the block is "ready" only in
// IDLE, and the single cycle where req[k] and grant[k] are both high is the
// transfer, so data[k] is sampled in that cycle. done is a valid-only strobe
// with no back-pressure; done_id/match_cnt are qualified by it.
module detect_scheduler
  import detect_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1),
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  done,
  output logic [IW-1:0]         done_id,
  output logic [CW-1:0]         match_cnt
);

  ctrl_state_t    state_q, state_d;
  logic [IW-1:0]  ptr_q;
  logic [IW-1:0]  pick;
  logic [IW-1:0]  scan_idx;
  logic           pick_vld;
  logic [IW-1:0]  next_ptr;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]  bit_cnt_q;
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  id_q;
  logic           accept;
  logic           last_bit;
  logic           hit;

  // Round-robin search starting at ptr_q; first set request wins.
  always_comb begin
    pick     = '0;
    scan_idx = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = IW'((int'(ptr_q) + i) % NREQ);
      if (!pick_vld && req[scan_idx]) begin
        pick_vld = 1'b1;
        pick     = scan_idx;
      end
    end
  end

  assign next_ptr = (pick == IW'(NREQ - 1)) ? '0 : pick + IW'(1);
  assign last_bit = (bit_cnt_q == CW'(WIDTH - 1));
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    grant   = '0;
    case (state_q)
      IDLE: begin
        // grant is combinational from req, so it is also gated by rst_n to
        // stay low while reset is held with requests pending.
        if (pick_vld && rst_n) begin
          accept      = 1'b1;
          grant[pick] = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      done_id   <= '0;
      match_cnt <= '0;
    end else if (accept) begin
      ptr_q     <= next_ptr;
      shreg_q   <= data[int'(pick)*WIDTH +: WIDTH];
      id_q      <= pick;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
    end else if (state_q == SHIFT) begin
      shreg_q   <= shreg_q << 1;
      bit_cnt_q <= bit_cnt_q + CW'(1);
      cnt_q     <= cnt_q + CW'(hit);
      // The last bit's hit is folded in here so the result is ready in DONE.
      if (last_bit) begin
        done_id   <= id_q;
        match_cnt <= cnt_q + CW'(hit);
      end
    end
  end

  // Cleared on every grant so a trailing 1 never pairs with the next job.
  seq10_detector u_det (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state_q == SHIFT),
    .x     (shreg_q[WIDTH-1]),
    .hit   (hit)
  );

endmodule

// File: doc/detect_scheduler.md
# detect_scheduler

Round-robin scheduler that shares one serial "10"-pattern detector between NREQ requesters. Each requester submits a WIDTH-bit word. The block grants one requester at a time, shifts the word MSB-first through the detector and counts detections. It then returns the count with a one-cycle done strobe tagged with the requester index. It sits between the word-level clients and the bit-serial detection datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, bits per submitted word (≥2)
- CW, $clog2(WIDTH+1), width of match_cnt (derived)
- IW, $clog2(NREQ), width of done_id (derived)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester request level
- data  in  NREQ*WIDTH  requester i word in data[i*WIDTH +: WIDTH]
- grant  out  NREQ  one-hot, one-cycle pulse when a request is accepted
- busy  out  1  high while a job is in progress (SHIFT or DONE)
- done  out  1  one-cycle pulse, match_cnt/done_id valid
- done_id  out  IW  index of the requester whose job completed
- match_cnt  out  CW  number of "10" detections in the word

## Operation
- Controller FSM states are IDLE, SHIFT and DONE.
- IDLE, no req: stay in IDLE; grant=0.
- IDLE, any req: grant the first set req[k] searching k = ptr, ptr+1, … mod NREQ.
  - Pulse grant[k].
  - Latch data word k and k into the job id.
  - Clear the detector (sync clr) and the bit counter and match counter.
  - ptr <= (k+1) mod NREQ.
  - Go to SHIFT.
- SHIFT: each cycle:
  - Present the next latched bit, MSB first, to the detector with en=1.
  - Increment the match counter when the detector's Mealy output is 1.
  - After WIDTH bits go to DONE.
- DONE:
  - done=1; done_id=job id; match_cnt=final count.
  - Return to IDLE.
  - done_id and match_cnt hold their values until the next DONE.
- Detector behaviour:
  - States S0 and S1. S1 means the previous bit was 1.
  - x=1 goes to S1 from either state. x=0 goes to S0.
  - Output is 1 iff state=S1 and x=0.
  - The count therefore equals the number of 1→0 adjacent-bit transitions inside the word.
  - clr forces S0. en=0 holds state, and the output is masked to 0.
- Requests are level-sensitive; data must be stable in the cycle req is high.
  - A requester still holding req in the next IDLE is served again subject to round-robin.
  - req is ignored outside IDLE.
- Reset (any time, including mid-job):
  - State=IDLE, ptr=0, detector=S0.
  - grant=0, busy=0, done=0, done_id=0, match_cnt=0.
  - An in-flight job is dropped without done.

## Timing
- Grant in cycle T.
- SHIFT occupies T+1 … T+WIDTH; bit WIDTH-1 is shifted at T+1 and bit 0 at T+WIDTH.
- done is high at T+WIDTH+1.
- The next grant is possible at T+WIDTH+2, so the sustained period is WIDTH+2 cycles per word.
- busy is high from T+1 through T+WIDTH+1 inclusive; grant and busy are never both high.
- match_cnt max is WIDTH/2 (floor), so CW never overflows.
- No cross-job pairing: the detector is cleared at grant, so a last bit of 1 never combines with the next job's first bit.

## Structure
- Shared package detect_pkg holds:
  - the controller state type (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the detector state type (S0=1'b0, S1=1'b1).
- Sub-module seq10_detector (clk, rst_n, clr, en, x, hit) implements the detector. It is instantiated once.
- Arbiter pointer, shift register, bit counter and match counter live in detect_scheduler.

## Test plan
- Reset: assert rst_n=0 mid-SHIFT → all outputs 0 immediately. After release with req=0, no done ever appears.
- Single job: req[0]=1, data0=8'b1010_1010 → grant[0] at T, busy T+1..T+9, done at T+9 with done_id=0, match_cnt=4.
- Counting: words 8'b1100_1100→2, 8'b1111_0000→1, 8'b0000_0001→0, 8'b0111_1111→0, 8'b1000_0000→1.
- No carry-over: job A=8'b0000_0001 then job B=8'b0111_1110 → counts 0 then 1.
- Round-robin: req=4'b1111 held continuously → grants in order 0,1,2,3,0. ptr=1 with req=4'b0101 → grant[2].
- Back-to-back throughput: two requesters always requesting → grants every WIDTH+2=10 cycles. Each done precedes the next grant by one cycle. match_cnt/done_id are stable between done pulses.
